// File: rtl/memory_coalesce_pkg.sv
// Shared types and defaults for the memory command coalesce controller.
package memory_coalesce_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } coalesce_ctrl_state_e;

  // Default threads per coalescing chunk (width of the TID bitmap).
  localparam int CTRL_DEFAULT_MAX_COALESCED = 8;
  // Default idle cycles in COLLECT before a forced issue.
  localparam int CTRL_DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/memory_cmd_coalesce_ctrl.sv
// Control sequencer for the LSU memory command coalesce buffer.
// Decides per cycle whether the buffer loads a new line, merges the
// incoming command or retires its entry, and owns the L1 request
// handshake plus the drain-on-flush protocol.
// Optional feature: define MEMORY_COALESCE_TIMEOUT_EN to force an issue
// after TIMEOUT_CYCLES idle cycles in COLLECT.
module memory_cmd_coalesce_ctrl
  import memory_coalesce_pkg::*;
#(
  parameter int NUM_MAX_COALESCED = CTRL_DEFAULT_MAX_COALESCED,
  parameter int TIMEOUT_CYCLES    = CTRL_DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         buf_match,
  input  logic [NUM_MAX_COALESCED-1:0] buf_tid_bitmap,
  output logic                         buf_incmd_valid,
  output logic                         buf_update_new,
  output logic                         buf_clear,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         busy
);

  coalesce_ctrl_state_e state_reg;
  coalesce_ctrl_state_e state_next;

  logic bitmap_full;
  logic accept;
  logic timeout_hit;

  // A line is complete once every thread slot has been merged.
  assign bitmap_full = &buf_tid_bitmap;
  assign accept      = in_valid && in_ready;
  assign busy        = (state_reg != IDLE);

`ifdef MEMORY_COALESCE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt_reg;
  logic [CNT_W-1:0] idle_cnt_next;

  assign timeout_hit = (idle_cnt_reg == CNT_LAST);

  // Idle counter: restarts on any accept or outside COLLECT, counts quiet COLLECT cycles.
  always_comb begin
    idle_cnt_next = idle_cnt_reg;
    if (accept || (state_reg != COLLECT)) begin
      idle_cnt_next = '0;
    end else if (!in_valid && !flush_req && !bitmap_full) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end
`else
  // Without the timeout feature COLLECT never exits on its own.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 2);
  assign timeout_hit = 1'b0;
`endif

  // Next-state and buffer/handshake control decode.
  always_comb begin
    state_next      = state_reg;
    in_ready        = 1'b0;
    buf_incmd_valid = 1'b0;
    buf_update_new  = 1'b0;
    buf_clear       = 1'b0;
    mem_req_valid   = 1'b0;
    flush_done      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready        = !flush_req;
        buf_incmd_valid = in_valid && !flush_req;
        flush_done      = flush_req;
        if (in_valid && !flush_req) begin
          state_next = in_last ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        if (flush_req) begin
          state_next = DRAIN;
        end else if (in_valid && buf_match) begin
          // Merge into the open line.
          in_ready        = 1'b1;
          buf_incmd_valid = 1'b1;
          state_next      = in_last ? DRAIN : COLLECT;
        end else if (in_valid) begin
          // Conflict: issue the old line and load the new command together.
          mem_req_valid = 1'b1;
          in_ready      = mem_req_ready;
          if (mem_req_ready) begin
            buf_clear       = 1'b1;
            buf_update_new  = 1'b1;
            buf_incmd_valid = 1'b1;
            state_next      = in_last ? DRAIN : COLLECT;
          end
        end else if (bitmap_full) begin
          state_next = DRAIN;
        end else if (timeout_hit) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          buf_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: tb/tb_memory_cmd_coalesce_ctrl.sv
// Self-checking bench for memory_cmd_coalesce_ctrl with a behavioural
// coalesce-buffer model and a line-grouping reference for random traffic.
module tb_memory_cmd_coalesce_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         buf_match;
  logic [N-1:0] buf_tid_bitmap;
  logic         buf_incmd_valid;
  logic         buf_update_new;
  logic         buf_clear;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         flush_req = 1'b0;
  logic         flush_done;
  logic         busy;

  logic [2:0]   cur_tid = '0;
  logic [31:0]  cur_addr = '0;

  // Buffer model: one open line with a TID bitmap.
  logic         bm_valid = 1'b0;
  logic [26:0]  bm_line = '0;
  logic [N-1:0] bm_bitmap = '0;

  assign buf_match      = bm_valid && (bm_line == cur_addr[31:5]);
  assign buf_tid_bitmap = bm_bitmap;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  bit rand_ready = 1'b0;
  logic [N-1:0] got_q[$];
  logic [N-1:0] exp_q[$];

  memory_cmd_coalesce_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .buf_match(buf_match), .buf_tid_bitmap(buf_tid_bitmap),
    .buf_incmd_valid(buf_incmd_valid), .buf_update_new(buf_update_new),
    .buf_clear(buf_clear), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .flush_req(flush_req),
    .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mid-cycle sample of everything the model and checks need.
  logic s_rst_n, s_acc, s_hs, s_mrv, s_mrr, s_in_ready, s_incmd, s_upd, s_clr;
  logic [2:0]  s_tid;
  logic [26:0] s_line;
  always @(negedge clk) begin
    s_rst_n    <= rst_n;
    s_acc      <= rst_n && in_valid && in_ready;
    s_hs       <= rst_n && mem_req_valid && mem_req_ready;
    s_mrv      <= mem_req_valid;
    s_mrr      <= mem_req_ready;
    s_in_ready <= in_ready;
    s_incmd    <= buf_incmd_valid;
    s_upd      <= buf_update_new;
    s_clr      <= buf_clear;
    s_tid      <= cur_tid;
    s_line     <= cur_addr[31:5];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and apply the buffer model's response to the DUT controls.
  task automatic tick();
    logic p_mrv, p_mrr, p_rst;
    p_mrv = s_mrv;
    p_mrr = s_mrr;
    p_rst = s_rst_n;
    @(posedge clk);
    #1;
    if (p_rst === 1'b1 && s_rst_n === 1'b1 && p_mrv === 1'b1 && p_mrr === 1'b0)
      check("req_hold", s_mrv, 1);
    check("upd_without_clr", s_upd & ~s_clr, 0);
    if (s_hs) got_q.push_back(bm_bitmap);
    if (s_acc) acc_cnt++;
    if (!s_rst_n) begin
      bm_valid = 1'b0; bm_bitmap = '0;
    end else if (s_clr) begin
      if (s_upd && s_incmd) begin
        bm_valid = 1'b1; bm_line = s_line; bm_bitmap = N'(1) << s_tid;
      end else begin
        bm_valid = 1'b0; bm_bitmap = '0;
      end
    end else if (s_incmd) begin
      if (!bm_valid) begin
        bm_valid = 1'b1; bm_line = s_line; bm_bitmap = N'(1) << s_tid;
      end else begin
        bm_bitmap = bm_bitmap | (N'(1) << s_tid);
      end
    end
    if (rand_ready) mem_req_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] tid, input logic [31:0] addr, input logic last,
                      output int cyc);
    cur_tid = tid; cur_addr = addr; in_last = last; in_valid = 1'b1; cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!s_acc && cyc < 64);
    check("send_accepted", s_acc, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_hs(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!s_hs && n < 64);
    check(tag, s_hs, 1);
  endtask

  task automatic pop_check(input string tag, input logic [N-1:0] exp);
    logic [N-1:0] b;
    check({tag, "_nreq"}, got_q.size(), 1);
    if (got_q.size() != 0) begin
      b = got_q.pop_front();
      check(tag, b, exp);
    end
    got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int c, tot, a0, found, n;
    @(negedge clk);
    @(posedge clk);
    #1;
    // Reset state
    tick(); tick();
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", {mem_req_valid, buf_incmd_valid, buf_clear, buf_update_new, flush_done}, 0);
    rst_n = 1'b1;
    tick();
    $display("step reset done");

    // Full line, in_last on the 8th thread
    mem_req_ready = 1'b0; a0 = acc_cnt; tot = 0;
    for (int t = 0; t < 8; t++) begin
      send(3'(t), 32'h1000 + 32'(4 * t), t == 7, c);
      tot += c;
    end
    check("t1_accepts", acc_cnt - a0, 8);
    check("t1_cycles", tot, 8);
    #1;
    check("t1_mrv_next", mem_req_valid, 1);
    check("t1_inready_drain", in_ready, 0);
    mem_req_ready = 1'b1;
    wait_hs("t1_hs");
    pop_check("t1_bitmap", 8'hFF);
    #1;
    check("t1_idle", busy, 0);
    $display("step full_line done");

    // Conflict with 3 cycles of back-pressure
    mem_req_ready = 1'b0;
    send(3'd0, 32'h100, 1'b0, c);
    cur_tid = 3'd1; cur_addr = 32'h200; in_last = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_inready_bp", s_in_ready, 0);
      check("t2_mrv_bp", s_mrv, 1);
    end
    mem_req_ready = 1'b1;
    tick();
    check("t2_replace", {s_clr, s_upd, s_incmd, s_in_ready}, 4'hF);
    in_valid = 1'b0;
    #1;
    check("t2_stay_collect", {busy, mem_req_valid}, 2'b10);
    pop_check("t2_old_line", 8'h01);
    send(3'd2, 32'h208, 1'b1, c);
    wait_hs("t2_hs");
    pop_check("t2_new_line", 8'h06);
    $display("step conflict done");

    // Bitmap full without in_last: one bubble then DRAIN
    mem_req_ready = 1'b1;
    for (int t = 0; t < 8; t++) send(3'(t), 32'h2000 + 32'(4 * t), 1'b0, c);
    #1;
    check("t3_bubble", {busy, mem_req_valid}, 2'b10);
    tick();
    #1;
    check("t3_drain", mem_req_valid, 1);
    tick();
    check("t3_hs", s_hs, 1);
    pop_check("t3_bitmap", 8'hFF);
    #1;
    check("t3_idle", busy, 0);
    $display("step bitmap_full done");

    // Timeout behaviour after a single load
    mem_req_ready = 1'b1;
    send(3'd3, 32'h3000, 1'b0, c);
    n = 0; found = 0;
    while (n < 40 && found == 0) begin
      tick();
      n++;
      if (s_mrv) found = n;
    end
`ifdef MEMORY_COALESCE_TIMEOUT_EN
    check("t4_timeout_latency", found, 17);
`else
    check("t4_no_timeout", found, 0);
    flush_req = 1'b1;
    wait_hs("t4_flush_hs");
    #1;
    check("t4_flush_done", flush_done, 1);
    flush_req = 1'b0;
`endif
    pop_check("t4_bitmap", 8'h08);
    tick();
    $display("step timeout done");

    // Flush in COLLECT with 2 cycles of back-pressure
    mem_req_ready = 1'b0;
    send(3'd0, 32'h4000, 1'b0, c);
    send(3'd1, 32'h4004, 1'b0, c);
    a0 = acc_cnt;
    cur_tid = 3'd2; cur_addr = 32'h4008; in_valid = 1'b1; flush_req = 1'b1;
    tick();
    check("t5_inready_collect", s_in_ready, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t5_inready_drain", {s_in_ready, s_mrv}, 2'b01);
    end
    mem_req_ready = 1'b1;
    tick();
    check("t5_hs", {s_in_ready, s_hs}, 2'b01);
    #1;
    check("t5_flush_done", {flush_done, busy, in_ready}, 3'b100);
    check("t5_no_accept", acc_cnt - a0, 0);
    pop_check("t5_bitmap", 8'h03);
    in_valid = 1'b0;
    tick();
    flush_req = 1'b0;
    tick();
    $display("step flush done");

    // Reset while DRAIN holds a request
    mem_req_ready = 1'b0;
    send(3'd5, 32'h5000, 1'b1, c);
    #1;
    check("t6_drain_mrv", mem_req_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_after_rst", {mem_req_valid, busy, in_ready}, 3'b001);
    check("t6_no_hs", got_q.size(), 0);
    got_q.delete();
    tick();
    $display("step reset_in_drain done");

    // Random instructions against the line-grouping reference
    rand_ready = 1'b1;
    exp_q.delete();
    for (int ins = 0; ins < 30; ins++) begin
      logic [2:0]  tids[$];
      logic [31:0] addrs[$];
      logic [N-1:0] grp;
      logic [26:0]  gline;
      for (int t = 0; t < 8; t++) begin
        if ($urandom_range(0, 1) != 0) begin
          tids.push_back(3'(t));
          addrs.push_back(32'h6000 + 32'(ins * 256) + (($urandom_range(0, 1) != 0) ? 32'h40 : 32'h0)
                          + 32'(4 * t));
        end
      end
      if (tids.size() == 0) begin
        tids.push_back(3'd4);
        addrs.push_back(32'h6000 + 32'(ins * 256) + 32'h10);
      end
      grp = '0; gline = '0;
      for (int i = 0; i < tids.size(); i++) begin
        if (grp != '0 && addrs[i][31:5] != gline) begin
          exp_q.push_back(grp);
          grp = '0;
        end
        gline = addrs[i][31:5];
        grp = grp | (N'(1) << tids[i]);
      end
      exp_q.push_back(grp);
      for (int i = 0; i < tids.size(); i++) begin
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) tick();
        send(tids[i], addrs[i], i == tids.size() - 1, c);
      end
    end
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("rnd_drained", busy, 0);
    check("rnd_nreq", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rnd_req%0d", i), got_q[i], exp_q[i]);
    $display("step random done reqs=%0d", got_q.size());
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
